// File: rtl/mux_rr_nx1_pkg.sv
// Shared constants for the mux_rr_nx1 family: mode encodings, default sizes
// and the round-robin pointer advance rule.
package mux_rr_nx1_pkg;

   localparam logic MODE_SEL  = 1'b0;
   localparam logic MODE_RR   = 1'b1;

   localparam int   DEF_N_CH  = 4;
   localparam int   DEF_WIDTH = 8;

   // Pointer moves to the slot just past the granted channel, wrapping at n.
   function automatic int next_ptr(input int g, input int n);
      return (g == n - 1) ? 0 : g + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Pure combinational rotate-priority arbiter: grants the first requester found
// when scanning from ptr upward with wrap-around.
module rr_arbiter_n #(
   parameter  int N_CH  = 4,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N_CH-1:0]  gnt,
   output logic [SEL_W-1:0] gnt_idx
);

   int   j;
   logic found;

   // NOTE: every output and temporary gets a default first, so no path leaves a value unassigned and no latch is inferred.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 0; k < N_CH; k++) begin
         j = int'(ptr) + k;
         if (j >= N_CH) j = j - N_CH;
         if (!found && req[j]) begin
            gnt[j]  = 1'b1;
            gnt_idx = SEL_W'(j);
            found   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_rr_nx1.sv
// N-channel valid/ready multiplexer with explicit-select or round-robin modes
// and a registered output. Define MUX_RR_LOCK_EN for packet-locked arbitration.
module mux_rr_nx1
   import mux_rr_nx1_pkg::*;
#(
   parameter  int N_CH  = DEF_N_CH,
   parameter  int WIDTH = DEF_WIDTH,
   localparam int SEL_W = $clog2(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      sel,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
`ifdef MUX_RR_LOCK_EN
   input  logic [N_CH-1:0]       in_last,
   output logic                  out_last,
`endif
   output logic [WIDTH-1:0]      out_data,
   output logic [SEL_W-1:0]      out_ch,
   output logic                  out_valid,
   input  logic                  out_ready
);

   logic [SEL_W-1:0] ptr;
   logic [N_CH-1:0]  arb_req;
   logic [N_CH-1:0]  rr_gnt;
   logic [SEL_W-1:0] rr_idx;
   logic [N_CH-1:0]  gnt;
   logic [SEL_W-1:0] g;
   logic [WIDTH-1:0] sel_data;
   logic             load;
   logic             xfer;

`ifdef MUX_RR_LOCK_EN
   logic             locked;
   logic [SEL_W-1:0] lock_ch;

   // While a packet is open only its channel may compete.
   always_comb begin
      for (int i = 0; i < N_CH; i++)
         arb_req[i] = in_valid[i] & (!locked || int'(lock_ch) == i);
   end
`else
   assign arb_req = in_valid;
`endif

   rr_arbiter_n #(.N_CH(N_CH)) u_arb (
      .req     (arb_req),
      .ptr     (ptr),
      .gnt     (rr_gnt),
      .gnt_idx (rr_idx)
   );

   assign load = !out_valid || out_ready;

   // Compare sel against each index instead of indexing, so out-of-range sel grants nothing.
   always_comb begin
      gnt = '0;
      g   = sel;
      if (mode == MODE_RR) begin
         gnt = rr_gnt;
         g   = rr_idx;
      end else begin
         for (int i = 0; i < N_CH; i++)
            gnt[i] = (int'(sel) == i) & in_valid[i];
      end
   end

   assign xfer     = load && (|gnt);
   assign in_ready = gnt & {N_CH{load & rst_n}};

   // AND-OR select on the one-hot grant; in_data is never indexed by sel.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < N_CH; i++)
         sel_data = sel_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= '0;
      end else begin
         if (xfer) begin
            out_data  <= sel_data;
            out_ch    <= g;
            out_valid <= 1'b1;
         end else if (load) begin
            out_valid <= 1'b0;
         end
         if (xfer && mode == MODE_RR)
            ptr <= SEL_W'(next_ptr(int'(g), N_CH));
      end
   end

`ifdef MUX_RR_LOCK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         locked   <= 1'b0;
         lock_ch  <= '0;
         out_last <= 1'b0;
      end else begin
         if (xfer)
            out_last <= |(gnt & in_last);
         if (mode == MODE_SEL) begin
            locked <= 1'b0;
         end else if (xfer) begin
            locked  <= !(|(gnt & in_last));
            lock_ch <= g;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Directed self-checking bench for mux_rr_nx1 (N_CH=4, WIDTH=8); the lock
// scenario is included when MUX_RR_LOCK_EN is defined.
module tb_mux_rr_nx1;

   logic        clk;
   logic        rst_n;
   logic        mode;
   logic [1:0]  sel;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_valid;
   logic        out_ready;
`ifdef MUX_RR_LOCK_EN
   logic [3:0]  in_last;
   logic        out_last;
`endif

   int errors = 0;
   int checks = 0;
   logic [7:0] d [4];

   mux_rr_nx1 #(.N_CH(4), .WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef MUX_RR_LOCK_EN
      .in_last   (in_last),
      .out_last  (out_last),
`endif
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input int ch);
      check({tag, " out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " out_ch"},    32'(out_ch),    32'(ch));
      check({tag, " out_data"},  32'(out_data),  32'(d[ch]));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "bench timed out");
   end

   initial begin
      d[0] = 8'h0F; d[1] = 8'h1B; d[2] = 8'hA5; d[3] = 8'h3C;
      in_data   = {d[3], d[2], d[1], d[0]};
      rst_n     = 1'b0;
      mode      = 1'b1;
      sel       = 2'd0;
      in_valid  = 4'b1111;
      out_ready = 1'b1;
`ifdef MUX_RR_LOCK_EN
      in_last   = 4'b1111;
`endif

      // Reset holds everything idle even with all channels valid.
      step();
      step();
      check("rst in_ready",  32'(in_ready),  32'h0);
      check("rst out_valid", 32'(out_valid), 32'h0);
      check("rst out_data",  32'(out_data),  32'h0);
      check("rst out_ch",    32'(out_ch),    32'h0);

      rst_n = 1'b1;
      #1;
      check("first grant in_ready", 32'(in_ready), 32'b0001);

      // Fair rotation with all channels valid.
      for (int i = 0; i < 8; i++) begin
         step();
         check_out($sformatf("rr rot %0d", i), i % 4);
      end

      // Only channels 0 and 3 valid: 1 and 2 are skipped.
      in_valid = 4'b1001;
      step(); check_out("rr skip 0", 0);
      step(); check_out("rr skip 1", 3);
      step(); check_out("rr skip 2", 0);
      step(); check_out("rr skip 3", 3);

      // Backpressure: output full and consumer stalled.
      in_valid  = 4'b1111;
      out_ready = 1'b0;
      #1;
      check("bp in_ready", 32'(in_ready), 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("bp hold in_ready %0d", i), 32'(in_ready), 32'h0);
         check_out($sformatf("bp hold %0d", i), 3);
      end
      out_ready = 1'b1;
      #1;
      check("bp release in_ready", 32'(in_ready), 32'b0001);
      step(); check_out("bp release", 0);

      // Explicit select.
      mode = 1'b0;
      sel  = 2'd2;
      #1;
      check("sel2 in_ready", 32'(in_ready), 32'b0100);
      step(); check_out("sel2", 2);
      in_valid = 4'b1011;
      #1;
      check("sel2 idle in_ready", 32'(in_ready), 32'h0);
      step();
      check("sel2 idle out_valid", 32'(out_valid), 32'h0);
      check("sel2 idle out_data",  32'(out_data),  32'(d[2]));
      check("sel2 idle out_ch",    32'(out_ch),    32'd2);

      // Pointer retained across mode switch; advance it to 3, then wrap.
      mode     = 1'b1;
      in_valid = 4'b1111;
      step(); check_out("ptr walk 1", 1);
      step(); check_out("ptr walk 2", 2);
      mode = 1'b0;
      sel  = 2'd1;
      step(); check_out("msw sel1 a", 1);
      step(); check_out("msw sel1 b", 1);
      mode = 1'b1;
      #1;
      check("msw rr in_ready", 32'(in_ready), 32'b1000);
      step(); check_out("msw rr 3", 3);
      step(); check_out("msw rr 0", 0);

      // No valid inputs in round-robin mode.
      in_valid = 4'b0000;
      #1;
      check("rr idle in_ready", 32'(in_ready), 32'h0);
      step();
      check("rr idle out_valid", 32'(out_valid), 32'h0);

      // Reset mid-operation discards the in-flight word asynchronously.
      in_valid = 4'b1111;
      step(); check_out("pre reset", 1);
      #2 rst_n = 1'b0;
      #1;
      check("async rst out_valid", 32'(out_valid), 32'h0);
      check("async rst in_ready",  32'(in_ready),  32'h0);
      #1 rst_n = 1'b1;
      #1;
      check("post rst in_ready", 32'(in_ready), 32'b0001);
      step(); check_out("post rst", 0);

`ifdef MUX_RR_LOCK_EN
      // Channel 1 sends a 3-word packet while channel 2 competes.
      in_valid = 4'b0110;
      in_last  = 4'b0100;
      step(); check_out("lock w0", 1);
      check("lock w0 last", 32'(out_last), 32'h0);
      step(); check_out("lock w1", 1);
      check("lock w1 last", 32'(out_last), 32'h0);
      in_last = 4'b0110;
      step(); check_out("lock w2", 1);
      check("lock w2 last", 32'(out_last), 32'h1);
      in_last = 4'b0000;
      step(); check_out("lock next", 2);
      check("lock next last", 32'(out_last), 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mux_rr_nx1.md
Name: mux_rr_nx1

Overview:
Parametrised N-channel, WIDTH-bit multiplexer with per-channel valid/ready handshakes and a registered output stage.
- Two selection modes: explicit select (classic mux behaviour), or round-robin arbitration among valid channels.
- Sits between multiple producer streams and a single consumer.
- Replaces the fixed 4:1 combinational mux wherever backpressure or fairness is needed.

Parameters:
N_CH, 4, number of input channels (>=2)
WIDTH, 8, data bits per channel
SEL_W (localparam), $clog2(N_CH), width of sel/out_ch

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
mode  in  1  0 = explicit select, 1 = round-robin
sel  in  SEL_W  channel index used when mode=0
in_data  in  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  in  N_CH  per-channel valid
in_ready  out  N_CH  per-channel ready, combinational, at most one bit set
out_data  out  WIDTH  registered data
out_ch  out  SEL_W  index of the channel that produced out_data
out_valid  out  1  output valid
out_ready  in  1  consumer ready

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values:
  - out_valid=0, out_data=0, out_ch=0, rr pointer ptr=0.
  - in_ready forced to 0 while rst_n=0.
- Load condition: load = !out_valid | out_ready. The output register accepts a new word only when load=1.
- Grant: a one-hot vector gnt[N_CH-1:0] is computed combinationally each cycle.
  - in_ready = gnt & {N_CH{load}}.
  - A transfer on channel g occurs when in_valid[g] & in_ready[g].
- Explicit mode (mode=0):
  - gnt[sel] = in_valid[sel].
  - If sel >= N_CH, gnt = 0 (no transfer, no error).
  - ptr is not modified.
- Round-robin mode (mode=1):
  - gnt selects the first i with in_valid[i]=1, searching ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1.
  - No valid inputs gives gnt=0.
  - On each transfer, ptr <= (g == N_CH-1) ? 0 : g+1.
  - ptr holds when there is no transfer.
- Output register update:
  - On a transfer: out_data <= in_data[g], out_ch <= g, out_valid <= 1, all on the same edge.
  - When load=1 and no transfer: out_valid <= 0. out_data and out_ch hold their previous values.
  - When load=0: all outputs hold.
- Latency: 1 cycle from an accepted input to out_valid. Full throughput of one word per cycle with out_ready tied high.
- Backpressure: out_valid=1 & out_ready=0 drives all in_ready to 0. Producers hold their data.
- Mode switch: takes effect on the next combinational arbitration. ptr is retained across mode changes. A word already in the output register is unaffected.
- Fairness: in mode 1 with all channels continuously valid, grants rotate 0,1,...,N_CH-1,0,...
- Reset mid-operation: any in-flight output word is discarded immediately (asynchronously). The first grant after reset in mode 1 goes to the lowest valid index.
- No X propagation: when sel is out of range, in_data is not indexed.

Optional Feature:
MUX_RR_LOCK_EN
- Adds ports in_last [N_CH-1:0] (in) and out_last [1] (out, registered, reset 0, loaded with in_last[g] on a transfer).
- In mode 1 the grant is locked to the current channel after a transfer with in_last=0. Other channels are not granted until that channel transfers with in_last=1. ptr then advances as normal.
- The lock is cleared by reset and by mode=0.
- Without the macro: no in_last/out_last ports, no lock, and arbitration is per word.

Decomposition:
- Shared header mux_defs.vh:
  - MODE_SEL=1'b0, MODE_RR=1'b1 constants.
  - The default N_CH/WIDTH values.
- One natural sub-module, rr_arbiter_n: a pure combinational rotate-priority arbiter.
  - Inputs: req[N_CH], ptr[SEL_W].
  - Outputs: one-hot gnt and encoded gnt_idx.
  - Reused by later arbitrated blocks.
- The ptr register stays in mux_rr_nx1.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0. Release rst_n, mode=1, out_ready=1 -> first grant ch0, out_ch=0 one cycle later.
- Explicit select: N_CH=4, mode=0, sel=2, in_valid=4'b1111, ch2 data=8'hA5 -> in_ready=4'b0100, next cycle out_data=8'hA5, out_ch=2. With sel=2 and in_valid[2]=0 -> no transfer, out_valid drops.
- Round-robin rotation: mode=1, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3. Then in_valid=4'b1001 -> grants alternate 0,3 and channels 1,2 are skipped.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles -> in_ready=0, out_data stable. Raise out_ready -> next word accepted that cycle and visible on the following edge.
- Mode switch and wrap: ptr=3 in mode 1, switch to mode=0 with sel=1 for 2 transfers, return to mode=1 with all channels valid -> next grant ch3, then ch0.
- With MUX_RR_LOCK_EN: ch1 sends 3 words with in_last=0,0,1 while ch2 is valid -> out_ch=1,1,1 then 2, and out_last asserts on the third word only.
